// File: rtl/byte_divider.sv
// Sequential unsigned restoring divider: one quotient bit per clock, start/ready/done
// handshake, results held in output registers until the next operation completes.
module byte_divider #(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] Quotient,
  output logic [WIDTH-1:0] Remainder,
  output logic             DivByZero
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           r_state, w_next;
  logic [WIDTH-1:0] r_div, r_q, r_rem;
  logic [CW-1:0]    r_cnt;

  logic [WIDTH:0]   w_s;
  logic [WIDTH+1:0] w_sum;
  logic             w_cout;
  logic [WIDTH-1:0] w_q_nxt, w_r_nxt;
  logic             w_last;

  // Trial subtraction as s + ~{0,divisor} + 1; the carry-out doubles as "no borrow".
  assign w_s     = {r_rem, r_q[WIDTH-1]};
  assign w_sum   = {1'b0, w_s} + {1'b0, ~{1'b0, r_div}} + {{(WIDTH+1){1'b0}}, 1'b1};
  assign w_cout  = w_sum[WIDTH+1];
  assign w_r_nxt = w_cout ? w_sum[WIDTH-1:0] : w_s[WIDTH-1:0];
  assign w_q_nxt = {r_q[WIDTH-2:0], w_cout};
  assign w_last  = (r_cnt == CW'(1));

  assign ready = (r_state == S_IDLE);
  assign done  = (r_state == S_DONE);

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = (B == '0) ? S_DONE : S_RUN;
      S_RUN:   if (w_last) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_div     <= '0;
      r_q       <= '0;
      r_rem     <= '0;
      r_cnt     <= '0;
      Quotient  <= '0;
      Remainder <= '0;
      DivByZero <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (start) begin
          if (B == '0) begin
            Quotient  <= '1;
            Remainder <= A;
            DivByZero <= 1'b1;
          end else begin
            r_div <= B;
            r_q   <= A;
            r_rem <= '0;
            r_cnt <= CW'(WIDTH);
          end
        end
        S_RUN: begin
          r_q   <= w_q_nxt;
          r_rem <= w_r_nxt;
          r_cnt <= r_cnt - CW'(1);
          if (w_last) begin
            Quotient  <= w_q_nxt;
            Remainder <= w_r_nxt;
            DivByZero <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_byte_divider.sv
// Directed bench for byte_divider: vector table plus hand-written handshake,
// ignored-start, mid-run reset and back-to-back sequences.
module tb_byte_divider;

  localparam int W = 8;

  logic         clock = 1'b0;
  logic         reset_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] A = '0, B = '0;
  logic         ready, done, DivByZero;
  logic [W-1:0] Quotient, Remainder;

  int n_vec = 0;
  int n_err = 0;

  byte_divider #(.WIDTH(W)) dut (
    .clock(clock), .reset_n(reset_n), .start(start), .A(A), .B(B),
    .ready(ready), .done(done), .Quotient(Quotient), .Remainder(Remainder),
    .DivByZero(DivByZero)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [W-1:0] a, b, q, r;
    logic         dz;
  } vec_t;

  vec_t vt[10];

  task automatic chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Issue one operation and check handshake timing, results and hold behaviour.
  task automatic run_op(input string nm, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] eq, input logic [W-1:0] er, input logic edz);
    int edges;
    int exp_edges;
    exp_edges = (b == 0) ? 0 : W;
    @(negedge clock);
    chk({nm, " ready_before"}, int'(ready), 1);
    A = a; B = b; start = 1'b1;
    @(posedge clock);
    @(negedge clock);
    start = 1'b0;
    A = ~a; B = ~b;
    chk({nm, " ready_drop"}, int'(ready), 0);
    edges = 0;
    while (!done && edges < 20) begin
      @(negedge clock);
      edges++;
    end
    chk({nm, " latency"}, edges, exp_edges);
    chk({nm, " quot"}, int'(Quotient), int'(eq));
    chk({nm, " rem"}, int'(Remainder), int'(er));
    chk({nm, " dz"}, int'(DivByZero), int'(edz));
    if (b != 0) begin
      chk({nm, " invariant"}, int'(Quotient) * int'(b) + int'(Remainder), int'(a));
      chk({nm, " rem_lt_b"}, int'(Remainder < b), 1);
    end
    @(negedge clock);
    chk({nm, " done_pulse"}, int'(done), 0);
    chk({nm, " ready_back"}, int'(ready), 1);
    chk({nm, " quot_hold"}, int'(Quotient), int'(eq));
  endtask

  initial begin
    int pulses, first_j, t1, t2;

    vt[0] = '{a: 200, b: 7,   q: 28,  r: 4,  dz: 0};
    vt[1] = '{a: 255, b: 1,   q: 255, r: 0,  dz: 0};
    vt[2] = '{a: 5,   b: 9,   q: 0,   r: 5,  dz: 0};
    vt[3] = '{a: 255, b: 255, q: 1,   r: 0,  dz: 0};
    vt[4] = '{a: 37,  b: 0,   q: 255, r: 37, dz: 1};
    vt[5] = '{a: 100, b: 10,  q: 10,  r: 0,  dz: 0};
    vt[6] = '{a: 0,   b: 5,   q: 0,   r: 0,  dz: 0};
    vt[7] = '{a: 1,   b: 2,   q: 0,   r: 1,  dz: 0};
    vt[8] = '{a: 254, b: 16,  q: 15,  r: 14, dz: 0};
    vt[9] = '{a: 128, b: 3,   q: 42,  r: 2,  dz: 0};

    #12;
    chk("rst ready", int'(ready), 1);
    chk("rst done", int'(done), 0);
    chk("rst quot", int'(Quotient), 0);
    chk("rst rem", int'(Remainder), 0);
    chk("rst dz", int'(DivByZero), 0);
    @(negedge clock);
    reset_n = 1'b1;

    for (int i = 0; i < 10; i++)
      run_op($sformatf("vec%0d", i), vt[i].a, vt[i].b, vt[i].q, vt[i].r, vt[i].dz);

    // start and operand changes during RUN must be ignored
    @(negedge clock);
    A = 200; B = 7; start = 1'b1;
    @(posedge clock);
    pulses = 0; first_j = -1;
    for (int j = 0; j < 14; j++) begin
      @(negedge clock);
      if (j == 0) start = 1'b0;
      if (j == 2) begin start = 1'b1; A = 9; B = 3; end
      if (j == 3) begin start = 1'b0; A = 77; B = 0; end
      if (done) begin
        pulses++;
        if (first_j < 0) first_j = j;
        chk("ign quot", int'(Quotient), 28);
        chk("ign rem", int'(Remainder), 4);
        chk("ign dz", int'(DivByZero), 0);
      end
    end
    chk("ign pulses", pulses, 1);
    chk("ign latency", first_j, W);

    // asynchronous reset in the third RUN cycle
    @(negedge clock);
    A = 200; B = 7; start = 1'b1;
    @(posedge clock);
    @(negedge clock); start = 1'b0;
    @(posedge clock);
    @(posedge clock);
    #2 reset_n = 1'b0;
    #1;
    chk("mrst ready", int'(ready), 1);
    chk("mrst done", int'(done), 0);
    chk("mrst quot", int'(Quotient), 0);
    chk("mrst rem", int'(Remainder), 0);
    @(negedge clock);
    reset_n = 1'b1;
    pulses = 0;
    for (int j = 0; j < 12; j++) begin
      @(negedge clock);
      if (done) pulses++;
    end
    chk("mrst no_done", pulses, 0);
    run_op("post_rst", 50, 6, 8, 2, 0);

    // start held high across two operations
    @(negedge clock);
    A = 60; B = 7; start = 1'b1;
    t1 = -1; t2 = -1;
    for (int t = 0; t < 40 && t2 < 0; t++) begin
      @(negedge clock);
      if (done) begin
        chk("b2b quot", int'(Quotient), 8);
        chk("b2b rem", int'(Remainder), 4);
        if (t1 < 0) t1 = t;
        else begin t2 = t; start = 1'b0; end
      end
    end
    start = 1'b0;
    chk("b2b first", t1, W);
    chk("b2b spacing", t2 - t1, W + 2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
